// File: rtl/key_event_queue.sv
// Debounced keypad event generator with optional auto-repeat, feeding a small
// FIFO that consumers drain through a valid/ready handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no key down; waiting for the synced pressed level
// PRESS_DB | candidate press captured in cur; counting stable cycles
// HELD     | press accepted; counting towards auto-repeat events
// REL_DB   | key appears released; counting stable cycles before IDLE
module key_event_queue #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [4:0]                 key_i,
    input  logic                       keypad_pressed_i,
    input  logic                       repeat_en_i,
    input  logic                       flush_i,
    input  logic                       out_ready_i,
    output logic                       out_valid_o,
    output logic [4:0]                 out_key_o,
    output logic                       out_repeat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0]  RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  RR_LAST = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    logic [4:0]     k_s1_q, k_s;
    logic           p_s1_q, p_s;

    state_t         state_q, state_d;
    logic [4:0]     cur_q, cur_d;
    logic [DBW-1:0] cnt_q, cnt_d;
    logic [RW-1:0]  rcnt_q, rcnt_d;
    logic           first_q, first_d;
    logic           push, push_rep;

    logic [5:0]     mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  count_q;
    logic           overflow_q;
    logic           full, pop, accept, ovf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_s1_q <= '0;
            k_s    <= '0;
            p_s1_q <= 1'b0;
            p_s    <= 1'b0;
        end else begin
            k_s1_q <= key_i;
            k_s    <= k_s1_q;
            p_s1_q <= keypad_pressed_i;
            p_s    <= p_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        first_d  = first_q;
        push     = 1'b0;
        push_rep = 1'b0;
        case (state_q)
            IDLE: begin
                if (p_s) begin
                    cur_d   = k_s;
                    cnt_d   = '0;
                    state_d = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!p_s || k_s != cur_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    push    = 1'b1;
                    rcnt_d  = '0;
                    first_d = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!p_s || k_s != cur_q) begin
                    cnt_d   = '0;
                    state_d = REL_DB;
                end else if (!repeat_en_i) begin
                    rcnt_d = '0;
                end else if (rcnt_q == (first_q ? RD_LAST : RR_LAST)) begin
                    push     = 1'b1;
                    push_rep = 1'b1;
                    rcnt_d   = '0;
                    first_d  = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            REL_DB: begin
                // a bounce back to the same key resumes HELD silently
                if (p_s && k_s == cur_q) begin
                    rcnt_d  = '0;
                    state_d = HELD;
                end else if (p_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        full   = (count_q == CW'(DEPTH));
        pop    = out_valid_o && out_ready_i;
        accept = push && (!full || pop);
        ovf_d  = push && full && !pop && !flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= ovf_d;
            if (flush_i) begin
                wr_q    <= '0;
                rd_q    <= '0;
                count_q <= '0;
            end else begin
                if (accept) begin
                    mem_q[wr_q] <= {cur_q, push_rep};
                    wr_q        <= wr_q + 1'b1;
                end
                if (pop) rd_q <= rd_q + 1'b1;
                case ({accept, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign out_valid_o  = (count_q != '0);
    assign out_key_o    = out_valid_o ? mem_q[rd_q][5:1] : 5'd0;
    assign out_repeat_o = out_valid_o ? mem_q[rd_q][0] : 1'b0;
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with short debounce/repeat timings.
module tb_key_event_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] key;
    logic       pressed, repeat_en, flush, out_ready;
    logic       out_valid, out_repeat, overflow;
    logic [4:0] out_key;
    logic [2:0] count;

    key_event_queue #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (5),
        .DEPTH          (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_i           (key),
        .keypad_pressed_i(pressed),
        .repeat_en_i     (repeat_en),
        .flush_i         (flush),
        .out_ready_i     (out_ready),
        .out_valid_o     (out_valid),
        .out_key_o       (out_key),
        .out_repeat_o    (out_repeat),
        .count_o         (count),
        .overflow_o      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] k;
        logic       rep;
        int         cyc;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  ovf_cnt = 0;
    int  n_pass = 0;
    int  n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every handshake and overflow pulse is logged mid-cycle.
    always @(negedge clk) begin
        if (out_valid && out_ready) evq.push_back('{out_key, out_repeat, cyc});
        if (overflow) ovf_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tap(input logic [4:0] k);
        key = k;
        pressed = 1'b1;
        step(10);
        pressed = 1'b0;
        step(10);
    endtask

    initial begin
        int b, bo, lat;
        rst_n = 1'b0;
        key = '0;
        pressed = 1'b0;
        repeat_en = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        step(3);
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_key", out_key, 0);
        check("rst_rep", out_repeat, 0);
        rst_n = 1'b1;
        step(2);

        // clean press: visible 7 edges after the press, for one cycle only
        b = evq.size();
        key = 5'h07;
        pressed = 1'b1;
        step(6);
        check("t1_early", out_valid, 0);
        step(1);
        check("t1_valid", out_valid, 1);
        check("t1_key", out_key, 5'h07);
        check("t1_rep", out_repeat, 0);
        step(1);
        check("t1_one_cycle", out_valid, 0);
        step(12);
        pressed = 1'b0;
        step(15);
        check("t1_events", evq.size() - b, 1);

        // press bounce, then a short release bounce while held
        b = evq.size();
        key = 5'h13;
        repeat (2) begin
            pressed = 1'b1;
            step(2);
            pressed = 1'b0;
            step(2);
        end
        pressed = 1'b1;
        step(10);
        pressed = 1'b0;
        step(2);
        pressed = 1'b1;
        step(10);
        pressed = 1'b0;
        step(12);
        check("t2_events", evq.size() - b, 1);
        check("t2_key", evq[b].k, 5'h13);
        check("t2_rep", evq[b].rep, 0);

        // auto-repeat: initial event then repeats at +10,+15,+20,+25
        b = evq.size();
        repeat_en = 1'b1;
        key = 5'h0A;
        pressed = 1'b1;
        step(33);
        pressed = 1'b0;
        step(12);
        repeat_en = 1'b0;
        check("t3_events", evq.size() - b, 5);
        check("t3_key0", evq[b].k, 5'h0A);
        check("t3_rep0", evq[b].rep, 0);
        for (int i = 1; i < 5; i++) begin
            check("t3_repk", evq[b+i].k, 5'h0A);
            check("t3_rep", evq[b+i].rep, 1);
            check("t3_gap", evq[b+i].cyc - evq[b].cyc, 10 + 5 * (i - 1));
        end

        // backpressure: six presses into four slots
        out_ready = 1'b0;
        bo = ovf_cnt;
        for (int k = 1; k <= 6; k++) tap(5'(k));
        check("t4_count", count, 4);
        check("t4_ovf", ovf_cnt - bo, 2);
        check("t4_head", out_key, 5'h01);
        b = evq.size();
        out_ready = 1'b1;
        step(6);
        check("t4_drained", evq.size() - b, 4);
        for (int i = 0; i < 4; i++) check("t4_order", evq[b+i].k, i + 1);
        check("t4_empty", count, 0);

        // full with a pop in the push cycle
        out_ready = 1'b0;
        for (int k = 5'h11; k <= 5'h14; k++) tap(5'(k));
        check("t5_full", count, 4);
        bo = ovf_cnt;
        key = 5'h15;
        pressed = 1'b1;
        step(6);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("t5_count", count, 4);
        check("t5_head", out_key, 5'h12);
        pressed = 1'b0;
        step(10);
        check("t5_no_ovf", ovf_cnt - bo, 0);

        // flush with three queued while a key is held
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;
        check("t5_pop2", count, 2);
        check("t5_head2", out_key, 5'h14);
        key = 5'h16;
        pressed = 1'b1;
        step(10);
        check("t5_three", count, 3);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 0);
        check("flush_key", out_key, 0);
        step(15);
        check("flush_norefire", count, 0);
        pressed = 1'b0;
        step(10);

        // reset while HELD with two queued, key kept down across reset
        tap(5'h1A);
        key = 5'h1B;
        pressed = 1'b1;
        step(10);
        check("t6_pre", count, 2);
        rst_n = 1'b0;
        #2;
        check("t6_valid", out_valid, 0);
        check("t6_count", count, 0);
        check("t6_key", out_key, 0);
        step(2);
        out_ready = 1'b1;
        b = evq.size();
        rst_n = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step(1);
            lat++;
        end
        check("t6_latency", lat, 7);
        check("t6_newkey", out_key, 5'h1B);
        check("t6_newrep", out_repeat, 0);
        step(10);
        pressed = 1'b0;
        step(10);
        check("t6_events", evq.size() - b, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
